// File: rtl/mem_agu_ctrl.sv
// Load/store address generation and memory-access controller for the data-memory stage.
// Forms the aligned effective address, runs a valid/ack access with timeout, and pulses completion.
module mem_agu_ctrl #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned OFF_W     = 4,
   parameter int unsigned OFF_SHIFT = 1,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_base,
   input  logic [OFF_W-1:0]  req_off,
   input  logic [1:0]        req_mode,
   input  logic              req_we,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              done_valid,
   output logic [DATA_W-1:0] done_rdata,
   output logic              done_err,
   output logic              misalign,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_base
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam int unsigned       CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << OFF_SHIFT) - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              wb_req, wb_req_nxt;
   logic              mem_en_nxt, mem_we_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt, wb_base_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt, done_rdata_nxt;
   logic              done_valid_nxt, done_err_nxt, misalign_nxt, wb_en_nxt;
   logic [ADDR_W-1:0] abase, off_ext, eff;

   // Aligned base plus scaled, sign-extended offset; wraps modulo 2^ADDR_W
   always_comb begin
      abase   = req_base & ~LOW_MASK;
      off_ext = {{(ADDR_W - OFF_W){req_off[OFF_W-1]}}, req_off} << OFF_SHIFT;
      eff     = abase + off_ext;
   end

   assign req_ready = (state == IDLE) && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      wb_req_nxt     = wb_req;
      mem_en_nxt     = mem_en;
      mem_we_nxt     = mem_we;
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
      done_valid_nxt = 1'b0;
      done_rdata_nxt = done_rdata;
      done_err_nxt   = done_err;
      misalign_nxt   = misalign;
      wb_en_nxt      = wb_en;
      wb_base_nxt    = wb_base;
      case (state)
         IDLE: begin
            if (req_valid) begin
               misalign_nxt = |(req_base & LOW_MASK);
               wb_base_nxt  = eff;
               wb_req_nxt   = req_mode[0] ^ req_mode[1];
               if (req_mode == 2'b11) begin
                  // Illegal mode completes with an error and never touches memory
                  state_nxt      = DONE;
                  done_valid_nxt = 1'b1;
                  done_err_nxt   = 1'b1;
                  done_rdata_nxt = '0;
                  wb_en_nxt      = 1'b0;
               end else begin
                  state_nxt     = ACCESS;
                  mem_en_nxt    = 1'b1;
                  mem_we_nxt    = req_we;
                  mem_addr_nxt  = (req_mode == 2'b10) ? abase : eff;
                  mem_wdata_nxt = req_wdata;
                  cnt_nxt       = CNT_W'(1);
               end
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               state_nxt      = DONE;
               mem_en_nxt     = 1'b0;
               mem_we_nxt     = 1'b0;
               cnt_nxt        = '0;
               done_valid_nxt = 1'b1;
               done_err_nxt   = 1'b0;
               done_rdata_nxt = mem_rdata;
               wb_en_nxt      = wb_req;
            end else if (cnt == CNT_MAX) begin
               state_nxt      = DONE;
               mem_en_nxt     = 1'b0;
               mem_we_nxt     = 1'b0;
               cnt_nxt        = '0;
               done_valid_nxt = 1'b1;
               done_err_nxt   = 1'b1;
               done_rdata_nxt = '0;
               wb_en_nxt      = 1'b0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         wb_req     <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         done_valid <= 1'b0;
         done_rdata <= '0;
         done_err   <= 1'b0;
         misalign   <= 1'b0;
         wb_en      <= 1'b0;
         wb_base    <= '0;
      end else begin
         cnt        <= cnt_nxt;
         wb_req     <= wb_req_nxt;
         mem_en     <= mem_en_nxt;
         mem_we     <= mem_we_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
         done_valid <= done_valid_nxt;
         done_rdata <= done_rdata_nxt;
         done_err   <= done_err_nxt;
         misalign   <= misalign_nxt;
         wb_en      <= wb_en_nxt;
         wb_base    <= wb_base_nxt;
      end
   end

endmodule

// File: doc/mem_agu_ctrl.md
# mem_agu_ctrl

Parametrised load/store address-generation and memory-access controller for the data-memory stage. It accepts one request at a time (base register, signed offset, addressing mode, store data), forms the word-aligned effective address with base writeback for indexed modes, and runs a valid/ack handshake to a multi-cycle data memory with a timeout. Results (read data, updated base, error and misalignment flags) return as a single-cycle completion pulse to the writeback logic.

## Interface
- ADDR_W, 16: address and base-register width.
- DATA_W, 16: memory data width.
- OFF_W, 4: signed offset width (two's complement).
- OFF_SHIFT, 1: offset scaling and alignment; base low OFF_SHIFT bits are forced to 0.
- TIMEOUT, 15: maximum ACCESS cycles waiting for mem_ack (>=1).

- clk  in  1  single clock; all registers update on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE with rst low.
- req_base  in  ADDR_W  base register value.
- req_off  in  OFF_W  signed offset.
- req_mode  in  2  00 offset, 01 pre-index+writeback, 10 post-index+writeback, 11 illegal.
- req_we  in  1  1 = store, 0 = load.
- req_wdata  in  DATA_W  store data.
- mem_en  out  1  memory request, held through ACCESS.
- mem_we  out  1  store strobe, valid with mem_en.
- mem_addr  out  ADDR_W  access address, registered.
- mem_wdata  out  DATA_W  store data, registered.
- mem_ack  in  1  memory completion; mem_rdata valid same cycle.
- mem_rdata  in  DATA_W  load data.
- done_valid  out  1  one-cycle completion pulse.
- done_rdata  out  DATA_W  load data captured on ack.
- done_err  out  1  timeout or illegal mode.
- misalign  out  1  base had nonzero low OFF_SHIFT bits; valid with done_valid.
- wb_en  out  1  base writeback enable, valid with done_valid.
- wb_base  out  ADDR_W  updated base value.

## Operation
- Arithmetic: abase = req_base with low OFF_SHIFT bits cleared; eff = abase + (sign-extend(req_off) << OFF_SHIFT), modulo 2^ADDR_W (wraps, no overflow flag).
- Mode 00: mem_addr = eff, wb_en = 0. Mode 01: mem_addr = eff, wb_base = eff. Mode 10: mem_addr = abase, wb_base = eff. Modes 01/10 assert wb_en only on successful completion.
- misalign = OR of req_base low OFF_SHIFT bits, captured at accept; access still proceeds on aligned address.
- States: IDLE -> ACCESS on accept (req_valid & req_ready), modes 00/01/10; IDLE -> DONE on accept of mode 11 (no memory access, done_err=1). ACCESS -> DONE on mem_ack (capture mem_rdata; done_err=0) or when wait counter reaches TIMEOUT with no ack (done_err=1, wb_en=0, done_rdata=0). DONE -> IDLE unconditionally.
- Ack and timeout in the same cycle: ack wins.
- mem_ack outside ACCESS is ignored.
- Request fields are captured at accept; later changes to req_* have no effect.
- Reset values: state IDLE, mem_en/mem_we/done_valid/done_err/misalign/wb_en = 0, mem_addr/mem_wdata/done_rdata/wb_base = 0, counter 0; req_ready = 0 while rst high.

## Timing
- Accept at edge E0; ACCESS cycles begin after E0: mem_en, mem_we, mem_addr, mem_wdata are valid from E0 until the edge where the ack is sampled.
- Ack sampled high at edge Ek -> done_valid high for exactly the cycle after Ek; minimum accept-to-done_valid = 2 edges (ack in first ACCESS cycle).
- Timeout: mem_en high for exactly TIMEOUT cycles, then one DONE cycle.
- Mode 11: done_valid in the cycle after E0; mem_en never asserts.
- req_ready low from E0 until return to IDLE; throughput one request per (ACCESS cycles + 2).
- Reset mid-operation: outputs drop asynchronously; no done_valid for the aborted request; req_ready high in the first cycle after rst deasserts.

## Test plan
- Mode 00, base 0x1001, off 4'hE (-2), load, ack in first ACCESS cycle, rdata 0xBEEF -> mem_addr 0x0FFC, mem_we 0, done_valid 2 edges after accept, done_rdata 0xBEEF, misalign 1, wb_en 0.
- Mode 01, base 0x0010, off +3, store 0x1234, ack after 3 cycles -> mem_addr 0x0016, mem_wdata 0x1234, mem_en high 3 cycles, wb_en 1, wb_base 0x0016.
- Mode 10, base 0xFFFE, off +1 -> mem_addr 0xFFFE, wb_base 0x0000 (wrap), wb_en 1, done_err 0.
- TIMEOUT=4, mode 01, no ack -> mem_en high 4 cycles, then done_valid with done_err 1, wb_en 0, done_rdata 0; spurious ack one cycle later ignored.
- Mode 11 accepted -> mem_en stays 0, done_valid and done_err 1 in next cycle, req_ready 1 the cycle after.
- rst pulsed in second ACCESS cycle -> mem_en 0 immediately, no done_valid, later ack ignored, req_ready 1 after release, next request completes normally.
